// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the pattern-history-table update path.
package bp_pkg;

    localparam int IDX_W  = 4;
    localparam int CTR_W  = 2;
    localparam int DEPTH  = 4;
    localparam int STAT_W = 16;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CTR_W-1:0] ctr_t;

    typedef struct packed {
        idx_t index;
        logic sel;
        ctr_t counter;
    } bp_entry_t;

    localparam ctr_t CTR_MAX = '1;

    // Saturating increment toward strongly-taken.
    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == CTR_MAX) ? c : c + ctr_t'(1);
    endfunction

    // Saturating decrement toward strongly-not-taken.
    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == '0) ? c : c - ctr_t'(1);
    endfunction

    // The counter MSB is the taken/not-taken prediction.
    function automatic logic pred_taken(input ctr_t c);
        return c[CTR_W-1];
    endfunction

endpackage

// File: rtl/bp_meta_fifo.sv
// In-order FIFO of in-flight branch metadata; clear wins over a same-cycle push.
module bp_meta_fifo
    import bp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  bp_entry_t        push_data,
    input  logic             pop,
    input  logic             clear,
    output bp_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    bp_entry_t        mem_q [DEPTH];
    bp_entry_t        mem_d [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    // A full FIFO drops the push even if a pop frees a slot this cycle.
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty;

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    // NOTE: storage is deliberately not reset; count gates every read, so stale
    // contents are never observed and the array can map to plain registers/RAM.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bp_update_unit.sv
// Write side of the 2-bit pattern history tables: pops branch metadata on resolve,
// computes the saturated counter, drives the table write port and keeps statistics.
module bp_update_unit
    import bp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [IDX_W-1:0]  push_index,
    input  logic              push_sel,
    input  logic [CTR_W-1:0]  push_counter,
    output logic              push_ready,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    input  logic              flush,
    output logic              update,
    output logic [IDX_W-1:0]  index_ex,
    output logic              sel,
    output logic [CTR_W-1:0]  counter_out,
    output logic              T,
    output logic              mispredict,
    output logic [CNT_W-1:0]  fifo_count,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispred_cnt,
    output logic              underflow_err
);

    bp_entry_t        head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop_fire;
    logic             mis_now;
    logic             fifo_clear;
    ctr_t             next_ctr;

    logic              update_q, update_d;
    idx_t              index_q, index_d;
    logic              sel_q, sel_d;
    ctr_t              ctr_q, ctr_d;
    logic              t_q, t_d;
    logic              mis_q, mis_d;
    logic [STAT_W-1:0] bcnt_q, bcnt_d;
    logic [STAT_W-1:0] mcnt_q, mcnt_d;
    logic              uf_q, uf_d;

    assign pop_fire   = resolve_valid && !fifo_empty;
    assign mis_now    = pop_fire && (pred_taken(head.counter) != resolve_taken);
    // Everything behind a mispredicted branch is wrong-path; flush squashes all too.
    assign fifo_clear = flush || mis_now;
    assign next_ctr   = resolve_taken ? sat_inc(head.counter) : sat_dec(head.counter);

    bp_meta_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_valid),
        .push_data ('{index: push_index, sel: push_sel, counter: push_counter}),
        .pop       (pop_fire),
        .clear     (fifo_clear),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign push_ready    = !fifo_full;
    assign update        = update_q;
    assign index_ex      = index_q;
    assign sel           = sel_q;
    assign counter_out   = ctr_q;
    assign T             = t_q;
    assign mispredict    = mis_q;
    assign branch_cnt    = bcnt_q;
    assign mispred_cnt   = mcnt_q;
    assign underflow_err = uf_q;

    // Table-write, statistics and error next-state; write fields hold between pops.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        update_d = 1'b0;
        mis_d    = 1'b0;
        index_d  = index_q;
        sel_d    = sel_q;
        ctr_d    = ctr_q;
        t_d      = t_q;
        bcnt_d   = bcnt_q;
        mcnt_d   = mcnt_q;
        uf_d     = uf_q;
        if (pop_fire) begin
            update_d = 1'b1;
            mis_d    = mis_now;
            index_d  = head.index;
            sel_d    = head.sel;
            ctr_d    = next_ctr;
            t_d      = resolve_taken;
            bcnt_d   = bcnt_q + 1'b1;
            if (mis_now) mcnt_d = mcnt_q + 1'b1;
        end else if (resolve_valid) begin
            uf_d = 1'b1;
        end
    end

    // Output, statistics and sticky-error registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            update_q <= 1'b0;
            index_q  <= '0;
            sel_q    <= 1'b0;
            ctr_q    <= '0;
            t_q      <= 1'b0;
            mis_q    <= 1'b0;
            bcnt_q   <= '0;
            mcnt_q   <= '0;
            uf_q     <= 1'b0;
        end else begin
            update_q <= update_d;
            index_q  <= index_d;
            sel_q    <= sel_d;
            ctr_q    <= ctr_d;
            t_q      <= t_d;
            mis_q    <= mis_d;
            bcnt_q   <= bcnt_d;
            mcnt_q   <= mcnt_d;
            uf_q     <= uf_d;
        end
    end

endmodule

// File: tb/tb_bp_update_unit.sv
// Self-checking bench for bp_update_unit: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_bp_update_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic [3:0]  push_index;
    logic        push_sel;
    logic [1:0]  push_counter;
    logic        push_ready;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        flush;
    logic        update;
    logic [3:0]  index_ex;
    logic        sel;
    logic [1:0]  counter_out;
    logic        T;
    logic        mispredict;
    logic [2:0]  fifo_count;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;
    logic        underflow_err;

    bp_update_unit dut (
        .clk           (clk),
        .rst           (rst),
        .push_valid    (push_valid),
        .push_index    (push_index),
        .push_sel      (push_sel),
        .push_counter  (push_counter),
        .push_ready    (push_ready),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .flush         (flush),
        .update        (update),
        .index_ex      (index_ex),
        .sel           (sel),
        .counter_out   (counter_out),
        .T             (T),
        .mispredict    (mispredict),
        .fifo_count    (fifo_count),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of in-flight branches and the expected output values.
    typedef struct {
        int idx;
        int sel;
        int ctr;
    } ent_t;

    ent_t        m_q[$];
    int          m_update, m_mis, m_idx, m_sel, m_ctr, m_t, m_uf;
    logic [15:0] m_bcnt, m_mcnt;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_update = 0; m_mis = 0; m_idx = 0; m_sel = 0; m_ctr = 0; m_t = 0; m_uf = 0;
        m_bcnt = '0; m_mcnt = '0;
    endtask

    // One clock: apply inputs, advance the model, then compare just after the edge.
    task automatic cycle(input int r, input int pv, input int pi, input int ps,
                         input int pc, input int rv, input int rt, input int fl);
        bit   full;
        bit   squash;
        ent_t e;
        rst           = (r != 0);
        push_valid    = (pv != 0);
        push_index    = 4'(pi);
        push_sel      = (ps != 0);
        push_counter  = 2'(pc);
        resolve_valid = (rv != 0);
        resolve_taken = (rt != 0);
        flush         = (fl != 0);
        @(posedge clk);
        if (r != 0) begin
            model_reset();
        end else begin
            full     = (m_q.size() == 4);
            squash   = 0;
            m_update = 0;
            m_mis    = 0;
            if (rv != 0) begin
                if (m_q.size() > 0) begin
                    e        = m_q.pop_front();
                    m_update = 1;
                    m_idx    = e.idx;
                    m_sel    = e.sel;
                    m_t      = rt;
                    m_ctr    = (rt != 0) ? ((e.ctr == 3) ? 3 : e.ctr + 1)
                                         : ((e.ctr == 0) ? 0 : e.ctr - 1);
                    m_mis    = ((e.ctr >= 2) != (rt != 0)) ? 1 : 0;
                    m_bcnt   = m_bcnt + 16'd1;
                    if (m_mis != 0) begin
                        m_mcnt = m_mcnt + 16'd1;
                        squash = 1;
                    end
                end else begin
                    m_uf = 1;
                end
            end
            if (pv != 0 && !full && !squash && fl == 0)
                m_q.push_back('{idx: pi & 15, sel: ps & 1, ctr: pc & 3});
            if (squash || fl != 0) m_q.delete();
        end
        #1;
        check("update",        int'(update),        m_update);
        check("mispredict",    int'(mispredict),    m_mis);
        check("index_ex",      int'(index_ex),      m_idx);
        check("sel",           int'(sel),           m_sel);
        check("counter_out",   int'(counter_out),   m_ctr);
        check("T",             int'(T),             m_t);
        check("fifo_count",    int'(fifo_count),    m_q.size());
        check("push_ready",    int'(push_ready),    (m_q.size() < 4) ? 1 : 0);
        check("branch_cnt",    int'(branch_cnt),    int'(m_bcnt));
        check("mispred_cnt",   int'(mispred_cnt),   int'(m_mcnt));
        check("underflow_err", int'(underflow_err), m_uf);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input int pi, input int ps, input int pc);
        cycle(0, 1, pi, ps, pc, 0, 0, 0);
    endtask

    task automatic resolve(input int rt);
        cycle(0, 0, 0, 0, 0, 1, rt, 0);
    endtask

    initial begin
        model_reset();
        // Reset held for two cycles.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 7, 1, 3, 1, 1, 0);
        idle();

        // 1: weakly-not-taken predicted, taken outcome -> mispredict, 01 -> 10.
        push(3, 0, 1);
        resolve(1);
        idle();

        // 2: strongly-taken stays saturated; strongly-not-taken stays at 00.
        push(5, 1, 3);
        resolve(1);
        push(9, 0, 0);
        resolve(0);

        // 3: fill, drop a fifth push, drain four correct predictions in order.
        push(1, 0, 3);
        push(2, 1, 2);
        push(4, 0, 3);
        push(6, 1, 2);
        push(8, 0, 3);
        for (int i = 0; i < 4; i++) resolve(1);

        // Push into a full FIFO while popping: push dropped, count drops by one.
        for (int i = 0; i < 4; i++) push(i + 10, 0, 0);
        cycle(0, 1, 15, 1, 0, 1, 0, 0);
        // Push and pop in the same non-full cycle: count unchanged.
        cycle(0, 1, 14, 1, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);

        // 4: mispredict squashes younger entries, then resolve on empty underflows.
        push(1, 0, 0);
        push(2, 1, 3);
        push(3, 0, 2);
        cycle(0, 1, 4, 0, 1, 1, 1, 0);
        idle();
        resolve(1);
        idle();

        // 5: flush with same-cycle resolve and push.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        push(7, 1, 2);
        push(11, 0, 1);
        cycle(0, 1, 12, 1, 3, 1, 1, 1);
        idle();

        // 6: reset mid-stream discards entries; no update follows.
        push(13, 0, 2);
        push(14, 1, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0) ? 1 : 0,
                  $urandom_range(0, 1),
                  $urandom_range(0, 15),
                  $urandom_range(0, 1),
                  $urandom_range(0, 3),
                  ($urandom_range(0, 2) == 0) ? 1 : 0,
                  $urandom_range(0, 1),
                  ($urandom_range(0, 19) == 0) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
